rt_router_param: RTL and testbench

- Parametrised successor to the fixed 16x16 bit-serial router. NPORT serial inputs are switched to NPORT serial outputs using the same frame_n/valid_n/din protocol.
- Adds round-robin arbitration for each output, a configurable pad length, and drop-on-contention with a per-input drop indication.
- Sits between the testbench agents (drivers and monitors) and any downstream consumer as the DUT of the router environment.

---
 rtl/rt_router_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_rt_router_param.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_router_param.sv
// rt_router_param: NPORT x NPORT bit-serial packet router.
//
// Each input carries packets on din/frame_n/valid_n. A packet has AW
// address bits (LSB first), then PAD idle cycles, then the payload.
// During the pad window the input asks its target output for a grant.
// Each output runs a round-robin arbiter and forwards the owning input
// with one register of latency. An input that has no grant when its pad
// window closes has its packet discarded and pulses drop_n.
//
// Ports:
//   clock     rising-edge system clock
//   reset_n   asynchronous active-low reset
//   din       serial data per input
//   frame_n   active-low frame per input
//   valid_n   active-low payload-bit valid per input
//   dout      serial data per output (registered)
//   valido_n  active-low valid per output (registered)
//   frameo_n  active-low frame per output (registered)
//   busy_n    active-low, output currently owned by an input
//   drop_n    active-low single-cycle pulse, packet on input discarded

// Per-input packet FSM: header capture, pad-window request, forward/drop.
module rt_router_in #(
   parameter int AW  = 4,
   parameter int PAD = 5
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          din,
   input  logic          frame_n,
   input  logic          gnt,
   output logic          req,
   output logic          fwd,
   output logic          rel,
   output logic          drop_n,
   output logic [AW-1:0] addr
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_PAD  = 3'd2;
   localparam logic [2:0] S_FWD  = 3'd3;
   localparam logic [2:0] S_DROP = 3'd4;

   logic [2:0] state;
   logic [3:0] cnt;
   logic       gnt_q;
   logic       addr_done, pad_end, in_hdr;

   assign addr_done = (cnt == 4'(AW - 1));
   assign pad_end   = (cnt == 4'(PAD - 1));
   assign in_hdr    = (state == S_ADDR) || (state == S_PAD);

   // A rising frame during the pad window is malformed, so it must not win.
   assign req = (state == S_PAD) && !gnt_q && !frame_n;
   assign fwd = (state == S_FWD);
   // Release on the last payload bit, or when a granted packet aborts early.
   assign rel = frame_n && (fwd || ((state == S_PAD) && gnt_q));

   // Drop is flagged in the deciding cycle itself; a same-cycle grant wins.
   always_comb begin
      drop_n = 1'b1;
      if (in_hdr && frame_n)
         drop_n = 1'b0;
      else if ((state == S_PAD) && pad_end && !gnt_q && !gnt)
         drop_n = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         gnt_q <= 1'b0;
         addr  <= '0;
      end else begin
         case (state)
            // IDLE already samples the first address bit; cnt is 0 here.
            S_IDLE, S_ADDR: begin
               if (frame_n) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  for (int b = 0; b < AW; b++)
                     if (cnt == 4'(b)) addr[b] <= din;
                  if (addr_done) begin
                     state <= S_PAD;
                     cnt   <= '0;
                  end else begin
                     state <= S_ADDR;
                     cnt   <= cnt + 4'd1;
                  end
               end
            end
            S_PAD: begin
               if (frame_n) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  gnt_q <= 1'b0;
               end else if (pad_end) begin
                  cnt <= '0;
                  if (gnt_q || gnt) begin
                     state <= S_FWD;
                     gnt_q <= 1'b1;
                  end else begin
                     state <= S_DROP;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
                  if (gnt) gnt_q <= 1'b1;
               end
            end
            S_FWD: begin
               if (frame_n) begin
                  state <= S_IDLE;
                  gnt_q <= 1'b0;
               end
            end
            S_DROP: begin
               if (frame_n) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// Per-output round-robin arbiter, ownership tracking and output register.
module rt_router_out #(
   parameter int NPORT = 16,
   parameter int AW    = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [NPORT-1:0] req,
   input  logic [NPORT-1:0] din,
   input  logic [NPORT-1:0] valid_n,
   input  logic [NPORT-1:0] frame_n,
   input  logic [NPORT-1:0] fwd,
   input  logic [NPORT-1:0] rel,
   output logic [NPORT-1:0] gnt,
   output logic             busy_n,
   output logic             dout,
   output logic             valido_n,
   output logic             frameo_n
);
   logic          busy, found;
   logic [AW-1:0] owner, ptr, win;

   assign busy_n = !busy;

   // Two passes: requesters at or above ptr first, then wrap to the lowest.
   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NPORT; i++)
         if (!busy && !found && req[i] && (AW'(i) >= ptr)) begin
            gnt[i] = 1'b1;
            win    = AW'(i);
            found  = 1'b1;
         end
      for (int i = 0; i < NPORT; i++)
         if (!busy && !found && req[i]) begin
            gnt[i] = 1'b1;
            win    = AW'(i);
            found  = 1'b1;
         end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy     <= 1'b0;
         owner    <= '0;
         ptr      <= '0;
         dout     <= 1'b0;
         valido_n <= 1'b1;
         frameo_n <= 1'b1;
      end else begin
         if (found) begin
            busy  <= 1'b1;
            owner <= win;
            ptr   <= (win == AW'(NPORT - 1)) ? '0 : win + 1'b1;
         end else if (busy && rel[owner]) begin
            busy <= 1'b0;
         end
         // A granted input still in its pad window does not drive the output.
         if (busy && fwd[owner]) begin
            dout     <= din[owner];
            valido_n <= valid_n[owner];
            frameo_n <= frame_n[owner];
         end else begin
            dout     <= 1'b0;
            valido_n <= 1'b1;
            frameo_n <= 1'b1;
         end
      end
   end
endmodule

module rt_router_param #(
   parameter int NPORT = 16,
   parameter int AW    = $clog2(NPORT),
   parameter int PAD   = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [NPORT-1:0] din,
   input  logic [NPORT-1:0] frame_n,
   input  logic [NPORT-1:0] valid_n,
   output logic [NPORT-1:0] dout,
   output logic [NPORT-1:0] valido_n,
   output logic [NPORT-1:0] frameo_n,
   output logic [NPORT-1:0] busy_n,
   output logic [NPORT-1:0] drop_n
);
   logic [NPORT-1:0]             req, fwd, rel, gnt;
   logic [NPORT-1:0][AW-1:0]     addr;
   logic [NPORT-1:0][NPORT-1:0]  oreq, ognt;   // [output][input]

   for (genvar gi = 0; gi < NPORT; gi++) begin : g_in
      rt_router_in #(.AW(AW), .PAD(PAD)) u_in (
         .clock   (clock),
         .reset_n (reset_n),
         .din     (din[gi]),
         .frame_n (frame_n[gi]),
         .gnt     (gnt[gi]),
         .req     (req[gi]),
         .fwd     (fwd[gi]),
         .rel     (rel[gi]),
         .drop_n  (drop_n[gi]),
         .addr    (addr[gi])
      );
   end

   // Steer each input's request to the output it addresses.
   always_comb begin
      oreq = '0;
      for (int j = 0; j < NPORT; j++)
         for (int i = 0; i < NPORT; i++)
            oreq[j][i] = req[i] && (addr[i] == AW'(j));
   end

   // Each input targets one output, so at most one row can grant it.
   always_comb begin
      gnt = '0;
      for (int j = 0; j < NPORT; j++)
         gnt = gnt | ognt[j];
   end

   for (genvar go = 0; go < NPORT; go++) begin : g_out
      rt_router_out #(.NPORT(NPORT), .AW(AW)) u_out (
         .clock    (clock),
         .reset_n  (reset_n),
         .req      (oreq[go]),
         .din      (din),
         .valid_n  (valid_n),
         .frame_n  (frame_n),
         .fwd      (fwd),
         .rel      (rel),
         .gnt      (ognt[go]),
         .busy_n   (busy_n[go]),
         .dout     (dout[go]),
         .valido_n (valido_n[go]),
         .frameo_n (frameo_n[go])
      );
   end
endmodule

// File: tb/tb_rt_router_param.sv
// Directed bench for rt_router_param (NPORT=16, AW=4, PAD=5).
// Packets are scheduled per input, driven cycle by cycle, and every output
// is monitored for received bits, in-frame valid pattern, frame ends and
// busy transitions; drop pulses are logged per input.
module tb_rt_router_param;
   localparam int NP  = 16;
   localparam int AW  = 4;
   localparam int PAD = 5;

   logic          clock, reset_n;
   logic [NP-1:0] din, frame_n, valid_n;
   logic [NP-1:0] dout, valido_n, frameo_n, busy_n, drop_n;

   rt_router_param #(.NPORT(NP), .AW(AW), .PAD(PAD)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .din      (din),
      .frame_n  (frame_n),
      .valid_n  (valid_n),
      .dout     (dout),
      .valido_n (valido_n),
      .frameo_n (frameo_n),
      .busy_n   (busy_n),
      .drop_n   (drop_n)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   // packet schedule per input
   int          st [NP];
   int          ab [NP];
   int          ns [NP];
   bit          act [NP];
   logic [3:0]  dst [NP];
   logic [31:0] pdata [NP];
   logic        sd [NP][64];
   logic        sv [NP][64];
   logic [63:0] evp [NP];

   // monitor state per output / drop log per input
   logic [63:0] rx [NP];
   logic [63:0] ovp [NP];
   int rxn [NP], nfc [NP], fe [NP], badend [NP], ofirst [NP];
   int bfall [NP], brise [NP], dropcnt [NP], dropcyc [NP];
   logic pf [NP], pb [NP];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      for (int j = 0; j < NP; j++) begin
         rx[j] = '0; ovp[j] = '0; rxn[j] = 0; nfc[j] = 0; fe[j] = 0; badend[j] = 0;
         ofirst[j] = -1; bfall[j] = -1; brise[j] = -1; dropcnt[j] = 0; dropcyc[j] = -1;
         pf[j] = frameo_n[j]; pb[j] = busy_n[j];
      end
   endtask

   task automatic start_pkt(input int i, input int d, input int dly, input int nb,
                            input logic [31:0] data, input bit gaps);
      int s;
      s = 0;
      st[i] = cyc + 2 + dly; dst[i] = 4'(d); ab[i] = -1; pdata[i] = data;
      evp[i] = '0; act[i] = 1'b1;
      for (int b = 0; b < nb; b++) begin
         if (gaps && b > 0 && $urandom_range(3) == 0) begin
            sd[i][s] = 1'b1; sv[i][s] = 1'b0; s++;
         end
         sd[i][s] = data[b]; sv[i][s] = 1'b1; evp[i][s] = 1'b1; s++;
      end
      ns[i] = s;
   endtask

   // Drives the inputs seen by the next rising edge (edge number cyc+1).
   task automatic drive();
      for (int i = 0; i < NP; i++) begin
         int o, s;
         logic f, v, d;
         f = 1'b1; v = 1'b1; d = 1'b0;
         o = cyc + 1 - st[i];
         if (act[i] && o >= 0) begin
            if (ab[i] >= 0 && o == ab[i]) act[i] = 1'b0;
            else if (o < AW) begin f = 1'b0; d = dst[i][o]; end
            else if (o < AW + PAD) f = 1'b0;
            else begin
               s = o - AW - PAD;
               if (s < ns[i]) begin
                  f = (s == ns[i] - 1); v = !sv[i][s]; d = sd[i][s];
               end else act[i] = 1'b0;
            end
         end
         frame_n[i] = f; valid_n[i] = v; din[i] = d;
      end
   endtask

   task automatic monitor();
      for (int j = 0; j < NP; j++) begin
         if (!frameo_n[j] || !pf[j]) begin
            if (nfc[j] < 64) ovp[j][nfc[j]] = !valido_n[j];
            nfc[j]++;
            if (!valido_n[j]) begin
               if (rxn[j] == 0) ofirst[j] = cyc;
               if (rxn[j] < 64) rx[j][rxn[j]] = dout[j];
               rxn[j]++;
            end
         end
         if (frameo_n[j] && !pf[j]) begin
            fe[j]++;
            if (valido_n[j]) badend[j]++;
         end
         if (busy_n[j] !== pb[j]) begin
            if (busy_n[j]) brise[j] = cyc; else bfall[j] = cyc;
         end
         pf[j] = frameo_n[j]; pb[j] = busy_n[j];
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      monitor();
      drive();
      #1;
      for (int i = 0; i < NP; i++)
         if (!drop_n[i]) begin dropcnt[i]++; dropcyc[i] = cyc + 1; end
   endtask

   function automatic int drops_total();
      int t;
      t = 0;
      for (int i = 0; i < NP; i++) t += dropcnt[i];
      return t;
   endfunction

   initial begin
      int s0, s1;
      reset_n = 1'b0;
      for (int i = 0; i < NP; i++) begin act[i] = 1'b0; st[i] = 0; ab[i] = -1; ns[i] = 0; end
      din = '0; frame_n = '1; valid_n = '1;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_dout", dout, 0);
      chk("rst_valido_n", valido_n, 16'hffff);
      chk("rst_frameo_n", frameo_n, 16'hffff);
      chk("rst_busy_n", busy_n, 16'hffff);
      chk("rst_drop_n", drop_n, 16'hffff);
      reset_n = 1'b1;
      cyc = 0;

      // single channel: in3 -> out10, 8'hA5
      clr_mon();
      start_pkt(3, 10, 0, 8, 32'hA5, 1'b0);
      s0 = st[3];
      repeat (25) step();
      chk("single_rx", rx[10][7:0], 8'hA5);
      chk("single_len", rxn[10], 8);
      chk("single_frames", fe[10], 1);
      chk("single_lastbit", badend[10], 0);
      chk("single_latency", ofirst[10], s0 + 9);
      chk("single_busy_fall", bfall[10], s0 + 4);
      chk("single_busy_rise", brise[10], s0 + 16);
      chk("single_drops", drops_total(), 0);

      // two inputs to distinct outputs, overlapping, with valid gaps
      clr_mon();
      start_pkt(0, 5, 0, 16, 32'hBEEF, 1'b1);
      start_pkt(7, 2, 2, 12, 32'h9C3, 1'b1);
      repeat (45) step();
      chk("dual_rx5", rx[5][15:0], 16'hBEEF);
      chk("dual_len5", rxn[5], 16);
      chk("dual_vpat5", ovp[5], evp[0]);
      chk("dual_rx2", rx[2][11:0], 12'h9C3);
      chk("dual_len2", rxn[2], 12);
      chk("dual_vpat2", ovp[2], evp[7]);
      chk("dual_first5", ofirst[5], st[0] + 9);
      chk("dual_first2", ofirst[2], st[7] + 9);
      chk("dual_drops", drops_total(), 0);

      // contention for out9, pointer at 0: in1 wins, in4 dropped
      clr_mon();
      start_pkt(1, 9, 0, 8, 32'h5A, 1'b0);
      start_pkt(4, 9, 0, 8, 32'h96, 1'b0);
      s0 = st[1];
      repeat (25) step();
      chk("cont1_rx", rx[9][7:0], 8'h5A);
      chk("cont1_len", rxn[9], 8);
      chk("cont1_drop4_cnt", dropcnt[4], 1);
      chk("cont1_drop4_cyc", dropcyc[4], s0 + 8);
      chk("cont1_drop1_cnt", dropcnt[1], 0);

      // same contention again, pointer now 2: in4 wins
      clr_mon();
      start_pkt(1, 9, 0, 8, 32'h5A, 1'b0);
      start_pkt(4, 9, 0, 8, 32'h96, 1'b0);
      s0 = st[1];
      repeat (25) step();
      chk("cont2_rx", rx[9][7:0], 8'h96);
      chk("cont2_len", rxn[9], 8);
      chk("cont2_drop1_cnt", dropcnt[1], 1);
      chk("cont2_drop1_cyc", dropcyc[1], s0 + 8);
      chk("cont2_drop4_cnt", dropcnt[4], 0);

      // late contender: in2's pad ends in the very cycle out6 is released
      clr_mon();
      start_pkt(0, 6, 0, 4, 32'h9, 1'b0);
      start_pkt(2, 6, 5, 8, 32'hE7, 1'b0);
      s0 = st[0];
      repeat (30) step();
      chk("late_rx", rx[6][11:0], 12'hE79);
      chk("late_len", rxn[6], 12);
      chk("late_frames", fe[6], 2);
      chk("late_drop2", dropcnt[2], 0);
      chk("late_busy_fall", bfall[6], s0 + 13);
      chk("late_busy_rise", brise[6], s0 + 21);

      // full load: every input to (i+1) mod 16, random payloads and gaps
      clr_mon();
      for (int i = 0; i < NP; i++) start_pkt(i, (i + 1) % NP, 0, 32, $urandom, 1'b1);
      repeat (80) step();
      for (int i = 0; i < NP; i++) begin
         int j;
         j = (i + 1) % NP;
         chk($sformatf("load_rx%0d", j), rx[j][31:0], pdata[i]);
         chk($sformatf("load_len%0d", j), rxn[j], 32);
         chk($sformatf("load_vpat%0d", j), ovp[j], evp[i]);
         chk($sformatf("load_nfc%0d", j), nfc[j], ns[i]);
      end
      chk("load_drops", drops_total(), 0);

      // reset during forwarding: in5 -> out12
      clr_mon();
      start_pkt(5, 12, 0, 16, 32'hA55A, 1'b0);
      repeat (12) step();
      chk("mid_frameo_before", frameo_n[12], 1'b0);
      reset_n = 1'b0;
      for (int i = 0; i < NP; i++) act[i] = 1'b0;
      drive();
      #1;
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_valido_n", valido_n, 16'hffff);
      chk("mid_rst_frameo_n", frameo_n, 16'hffff);
      chk("mid_rst_busy_n", busy_n, 16'hffff);
      chk("mid_rst_drop_n", drop_n, 16'hffff);
      step();
      chk("mid_no_drop", dropcnt[5], 0);
      // next packet has frame_n already low when reset deasserts
      clr_mon();
      start_pkt(5, 12, 0, 8, 32'h3E, 1'b0);
      step();
      reset_n = 1'b1;
      repeat (22) step();
      chk("post_rst_rx", rx[12][7:0], 8'h3E);
      chk("post_rst_len", rxn[12], 8);
      chk("post_rst_drops", drops_total(), 0);

      // malformed: frame_n rises during the address field
      clr_mon();
      start_pkt(6, 3, 0, 8, 32'hF0, 1'b0);
      ab[6] = 2;
      s1 = st[6];
      repeat (20) step();
      chk("bad_drop_cnt", dropcnt[6], 1);
      chk("bad_drop_cyc", dropcyc[6], s1 + 2);
      chk("bad_no_out", rxn[3], 0);
      chk("bad_no_busy", bfall[3], -1);
      clr_mon();
      start_pkt(6, 3, 0, 8, 32'h81, 1'b0);
      repeat (22) step();
      chk("bad_next_rx", rx[3][7:0], 8'h81);
      chk("bad_next_len", rxn[3], 8);
      chk("bad_next_drop", dropcnt[6], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end
endmodule
